norm_round_pipe: RTL and testbench

- Parametrised, pipelined successor of the MAC stage-4 normaliser.
- Takes the signed aligned sum and the block maximum exponent from the adder stage, and produces sign, normalised mantissa (hidden one included) and final exponent.
- Rounding is true round-to-nearest-even using guard and sticky bits, and the result is range-checked against the target format.
- Two-stage pipeline with valid/ready handshake on both sides, so the MAC datapath can stall without losing results.

---
 rtl/norm_round_pipe.sv | 163 ++++++++++++++++
 tb/tb_norm_round_pipe.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_round_pipe.sv
// Two-stage normaliser with round-to-nearest-even and exponent range check.
// Define NORM_SAT_EN to saturate the result on exponent overflow.
module norm_round_pipe #(
  parameter int unsigned SUM_W  = 20,
  parameter int unsigned EXP_W  = 6,
  parameter int unsigned MAN_W  = 11,
  parameter int unsigned EOUT_W = 7,
  parameter int          EXP_HI = 15,
  parameter int          EXP_LO = -14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SUM_W-1:0]  signed_sum,
  input  logic [EXP_W-1:0]  exp_max,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign,
  output logic [MAN_W-1:0]  norm_sum,
  output logic [EOUT_W-1:0] exp_final,
  output logic              zero,
  output logic              ovf,
  output logic              udf
);

  localparam int unsigned PW = $clog2(SUM_W);
  // Wide enough that exp_max + shift + carry never wraps before the range check.
  localparam int unsigned FW = ((EXP_W > PW) ? EXP_W : PW) + 3;
  localparam logic signed [FW-1:0] EHI = FW'(EXP_HI);
  localparam logic signed [FW-1:0] ELO = FW'(EXP_LO);

  logic s1_valid, s2_valid, s1_load, s2_load;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  // Stage 1: magnitude and leading-one position
  logic [SUM_W-1:0] mag_c;
  logic [PW-1:0]    p_c;
  logic             zero_c;

  always_comb begin
    mag_c = signed_sum[SUM_W-1] ? (~signed_sum + 1'b1) : signed_sum;
    p_c   = '0;
    for (int i = 0; i < SUM_W; i++) begin
      if (mag_c[i]) p_c = PW'(i);
    end
    zero_c = (mag_c == '0);
  end

  logic             s1_sign, s1_zero;
  logic [SUM_W-1:0] s1_mag;
  logic [PW-1:0]    s1_p;
  logic [EXP_W-1:0] s1_exp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_mag   <= '0;
      s1_p     <= '0;
      s1_exp   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= signed_sum[SUM_W-1];
        s1_zero <= zero_c;
        s1_mag  <= mag_c;
        s1_p    <= p_c;
        s1_exp  <= exp_max;
      end
    end
  end

  // Stage 2: shift, round, exponent adjust and range check
  logic [MAN_W-1:0]       mant, mant_fin;
  logic [MAN_W:0]         mant_rnd;
  logic [SUM_W-1:0]       low_mask;
  logic                   guard, sticky, round_up, carry;
  logic signed [FW-1:0]   exp_full;
  logic                   ovf_c, udf_c;
  logic                   sign_d, zero_d, ovf_d, udf_d;
  logic [MAN_W-1:0]       norm_d;
  logic [EOUT_W-1:0]      exp_d;

  always_comb begin
    mant     = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    low_mask = '0;
    if (32'(s1_p) <= MAN_W - 1) begin
      mant = MAN_W'(s1_mag << (MAN_W - 1 - 32'(s1_p)));
    end else begin
      mant     = MAN_W'(s1_mag >> (32'(s1_p) - (MAN_W - 1)));
      guard    = s1_mag[s1_p - PW'(MAN_W)];
      low_mask = ~({SUM_W{1'b1}} << (s1_p - PW'(MAN_W)));
      sticky   = |(s1_mag & low_mask);
    end
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
    carry    = mant_rnd[MAN_W];
    mant_fin = carry ? {1'b1, {(MAN_W-1){1'b0}}} : mant_rnd[MAN_W-1:0];
    exp_full = {{(FW-EXP_W){s1_exp[EXP_W-1]}}, s1_exp} + FW'(s1_p)
             - FW'(MAN_W - 1) + FW'(carry);
    ovf_c    = exp_full > EHI;
    udf_c    = exp_full < ELO;

    sign_d = s1_sign;
    norm_d = mant_fin;
    exp_d  = EOUT_W'(exp_full);
    zero_d = 1'b0;
    ovf_d  = 1'b0;
    udf_d  = 1'b0;
    if (s1_zero) begin
      sign_d = 1'b0;
      norm_d = '0;
      exp_d  = '0;
      zero_d = 1'b1;
    end else if (udf_c) begin
      // Flush to zero but keep the sign of the tiny value
      norm_d = '0;
      exp_d  = '0;
      zero_d = 1'b1;
      udf_d  = 1'b1;
    end else if (ovf_c) begin
      ovf_d = 1'b1;
`ifdef NORM_SAT_EN
      norm_d = '1;
      exp_d  = EOUT_W'(EXP_HI);
`else
      norm_d = mant_fin;
      exp_d  = EOUT_W'(exp_full);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid  <= 1'b0;
      sign      <= 1'b0;
      norm_sum  <= '0;
      exp_final <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sign      <= sign_d;
        norm_sum  <= norm_d;
        exp_final <= exp_d;
        zero      <= zero_d;
        ovf       <= ovf_d;
        udf       <= udf_d;
      end
    end
  end

endmodule

// File: tb/tb_norm_round_pipe.sv
// Self-checking bench for norm_round_pipe: directed vectors, random traffic with
// backpressure against an arithmetic reference model, stall and reset scenarios.
module tb_norm_round_pipe;

  typedef struct packed {
    logic        sign;
    logic [10:0] norm;
    logic [6:0]  ex;
    logic        zero;
    logic        ovf;
    logic        udf;
  } res_t;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [19:0] signed_sum;
  logic [5:0]  exp_max;
  logic        sign, zero, ovf, udf;
  logic [10:0] norm_sum;
  logic [6:0]  exp_final;
  res_t        act;

  int errors = 0;
  int checks = 0;
  res_t q[$];

  assign act = {sign, norm_sum, exp_final, zero, ovf, udf};

  norm_round_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .signed_sum(signed_sum),
    .exp_max   (exp_max),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .norm_sum  (norm_sum),
    .exp_final (exp_final),
    .zero      (zero),
    .ovf       (ovf),
    .udf       (udf)
  );

  always #5 clk = ~clk;

  // Reference: value-level rounding via remainder against half an ulp.
  function automatic res_t model(input logic [19:0] s, input logic [5:0] e6);
    res_t   r;
    longint mag, mant, rem, half;
    int     p, sh, ef, carry, e;
    r     = '0;
    e     = int'($signed(e6));
    mag   = s[19] ? ((longint'(1) << 20) - longint'(s)) : longint'(s);
    if (mag == 0) begin
      r.zero = 1'b1;
      return r;
    end
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    carry = 0;
    if (p <= 10) begin
      mant = mag << (10 - p);
    end else begin
      sh   = p - 10;
      mant = mag >> sh;
      rem  = mag - (mant << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant++;
      if (mant == 2048) begin
        mant  = 1024;
        carry = 1;
      end
    end
    ef     = e + p - 10 + carry;
    r.sign = s[19];
    if (ef < -14) begin
      r.udf  = 1'b1;
      r.zero = 1'b1;
    end else if (ef > 15) begin
      r.ovf = 1'b1;
`ifdef NORM_SAT_EN
      r.norm = 11'h7FF;
      r.ex   = 7'd15;
`else
      r.norm = mant[10:0];
      r.ex   = ef[6:0];
`endif
    end else begin
      r.norm = mant[10:0];
      r.ex   = ef[6:0];
    end
    return r;
  endfunction

  function automatic logic [19:0] rand_sum();
    int unsigned k;
    logic [19:0] v;
    k = $urandom_range(9, 0);
    if (k < 4) begin
      v = 20'($urandom);
    end else if (k < 8) begin
      v = 20'($urandom_range(4095, 0));
      if ($urandom_range(1, 0) == 1) v = -v;
    end else if (k == 8) begin
      v = 20'h80000;
    end else begin
      v = 20'h0;
    end
    return v;
  endfunction

  task automatic test_reset();
    #3;
    checks++;
    if (out_valid !== 1'b0 || act !== res_t'(0))
      $display("FAIL reset_state: out_valid=%b outs=%h expected 0/0", out_valid, act);
    if (out_valid !== 1'b0 || act !== res_t'(0)) errors++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [19:0] sums[8] = '{20'h00400, 20'h00C03, 20'h00C01, 20'h00FFF,
                             20'hFFC00, 20'h80000, 20'h00000, 20'h00001};
    logic [5:0]  exps[8] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd10, 6'd0, 6'h38};
    res_t exp_r;
    int   lat;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      signed_sum = sums[i];
      exp_max    = exps[i];
      in_valid   = 1'b1;
      exp_r      = model(sums[i], exps[i]);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      checks++;
      if (lat != 2) begin
        errors++;
        $display("FAIL dir_latency[%0d]: got %0d cycles expected 2", i, lat);
      end
      checks++;
      if (act !== exp_r) begin
        errors++;
        $display("FAIL dir_result[%0d] sum=%h: got %h expected %h", i, sums[i], act, exp_r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    res_t e, snap;
    logic stall_prev;
    stall_prev = 1'b0;
    snap       = '0;
    for (int c = 0; c < 600; c++) begin
      in_valid   = ($urandom_range(99, 0) < 70);
      out_ready  = ($urandom_range(99, 0) < 65);
      signed_sum = rand_sum();
      exp_max    = 6'($urandom_range(63, 0));
      @(negedge clk);
      checks++;
      if (in_ready !== ((q.size() < 2) || out_ready)) begin
        errors++;
        $display("FAIL rnd_in_ready: got %b inflight=%0d out_ready=%b", in_ready, q.size(),
                 out_ready);
      end
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || act !== snap) begin
          errors++;
          $display("FAIL rnd_hold: got v=%b %h expected v=1 %h", out_valid, act, snap);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra: got unexpected result %h expected none", act);
        end else begin
          e = q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL rnd_result: got %h expected %h", act, e);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(signed_sum, exp_max));
      stall_prev = out_valid && !out_ready;
      snap       = act;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() != 0; c++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        e = q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL rnd_drain: got %h expected %h", act, e);
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rnd_lost: got %0d results missing expected 0", q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] bp_sum[4] = '{20'h00C03, 20'hFFC00, 20'h12345, 20'h00FFF};
    res_t e, snap;
    int   sent;
    sent      = 0;
    snap      = '0;
    out_ready = 1'b0;
    exp_max   = 6'd1;
    for (int c = 0; c < 6; c++) begin
      in_valid   = 1'b1;
      signed_sum = bp_sum[sent];
      @(negedge clk);
      if (c == 2) snap = act;
      if (c == 5) begin
        checks++;
        if (in_ready !== 1'b0 || sent != 2) begin
          errors++;
          $display("FAIL bp_full: got in_ready=%b accepted=%0d expected 0/2", in_ready, sent);
        end
        checks++;
        if (out_valid !== 1'b1 || act !== snap) begin
          errors++;
          $display("FAIL bp_hold: got v=%b %h expected v=1 %h", out_valid, act, snap);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(signed_sum, exp_max));
        sent++;
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (sent < 4 || q.size() != 0); c++) begin
      in_valid = (sent < 4);
      if (sent < 4) signed_sum = bp_sum[sent];
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL bp_dup: got extra result %h expected none", act);
        end else begin
          e = q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL bp_order: got %h expected %h", act, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(signed_sum, exp_max));
        sent++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (q.size() != 0 || sent != 4) begin
      errors++;
      $display("FAIL bp_count: got sent=%0d pending=%0d expected 4/0", sent, q.size());
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle: got out_valid=%b expected 0", out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midstream();
    logic seen;
    seen       = 1'b0;
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    exp_max    = 6'd0;
    signed_sum = 20'h00400;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_fill: got v=%b in_ready=%b expected 1/0", out_valid, in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || act !== res_t'(0)) begin
      errors++;
      $display("FAIL mid_async: got v=%b %h expected 0/0", out_valid, act);
    end
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_stale: got stale=%b in_ready=%b expected 0/1", seen, in_ready);
    end
  endtask

  initial begin
    clk        = 1'b0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    signed_sum = '0;
    exp_max    = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
